// File: rtl/trig_capture_if.sv
// rtl/trig_capture_if.sv - sample stream and window read port bundle for trig_capture
//   s_valid/s_data : filtered sample strobe and value (driven by the master)
//   rd_addr        : logical window read index, 0 = oldest (driven by the master)
//   rd_data        : registered window sample (driven by the slave)
interface trig_capture_if #(
    parameter int DATA_SIZE = 16,
    parameter int ADDR_SIZE = 10
);
    logic                 s_valid;
    logic [DATA_SIZE-1:0] s_data;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [DATA_SIZE-1:0] rd_data;

    modport master (output s_valid, output s_data, output rd_addr, input rd_data);
    modport slave  (input s_valid, input s_data, input rd_addr, output rd_data);
endinterface

// File: rtl/trig_capture.sv
// rtl/trig_capture.sv - edge trigger with pre-trigger depth and circular capture window
//   clk, rstn            : clock, asynchronous active-low reset
//   arm                  : starts/restarts a capture, latches trig_level/trig_edge/pretrig
//   trig_edge            : 0 = rising, 1 = falling crossing of trig_level
//   pretrig              : samples kept before the trigger sample
//   force_trig           : forces a trigger (held pending if it arrives before WAIT_TRIG)
//   s_if                 : sample stream in, oldest-first window read port out
//   busy/triggered/capt_done : capture status
module trig_capture #(
    parameter int DATA_SIZE = 16,
    parameter int ADDR_SIZE = 10,
    parameter int DEPTH     = 2**ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 arm,
    input  logic [DATA_SIZE-1:0] trig_level,
    input  logic                 trig_edge,
    input  logic [ADDR_SIZE-1:0] pretrig,
    input  logic                 force_trig,
    trig_capture_if.slave        s_if,
    output logic                 busy,
    output logic                 triggered,
    output logic                 capt_done
);
    typedef enum logic [2:0] {S_IDLE, S_PREFILL, S_WAIT_TRIG, S_POST, S_DONE} state_t;

    localparam logic [ADDR_SIZE:0] DEPTH_M1 = (ADDR_SIZE+1)'(DEPTH - 1);

    logic [DATA_SIZE-1:0] mem [DEPTH];

    state_t               state_q, state_d;
    logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0] start_ptr_q, start_ptr_d;
    logic [ADDR_SIZE:0]   pre_cnt_q, pre_cnt_d;
    logic [ADDR_SIZE:0]   post_cnt_q, post_cnt_d;
    logic [DATA_SIZE-1:0] level_q, level_d;
    logic                 edge_q, edge_d;
    logic [ADDR_SIZE-1:0] pretrig_q, pretrig_d;
    logic [DATA_SIZE-1:0] prev_q, prev_d;
    logic                 have_prev_q, have_prev_d;
    logic                 pend_force_q, pend_force_d;
    logic                 triggered_q, triggered_d;
    logic                 capt_done_q, capt_done_d;
    logic [DATA_SIZE-1:0] rd_data_q, rd_data_d;

    logic                 wr_en;
    logic                 lvl_hit;
    logic [ADDR_SIZE:0]   post_init;

    // Crossing test against the previous stored sample; the first sample after arm has no history.
    always_comb begin
        lvl_hit = 1'b0;
        if (have_prev_q) begin
            if (edge_q)
                lvl_hit = (prev_q >= level_q) && (s_if.s_data < level_q);
            else
                lvl_hit = (prev_q < level_q) && (s_if.s_data >= level_q);
        end
    end

    assign post_init = DEPTH_M1 - {1'b0, pretrig_q};

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        start_ptr_d  = start_ptr_q;
        pre_cnt_d    = pre_cnt_q;
        post_cnt_d   = post_cnt_q;
        level_d      = level_q;
        edge_d       = edge_q;
        pretrig_d    = pretrig_q;
        prev_d       = prev_q;
        have_prev_d  = have_prev_q;
        pend_force_d = pend_force_q;
        triggered_d  = triggered_q;
        capt_done_d  = capt_done_q;
        wr_en        = 1'b0;

        if (arm) begin
            // arm overrides everything, including a sample arriving in the same cycle
            level_d      = trig_level;
            edge_d       = trig_edge;
            pretrig_d    = pretrig;
            wr_ptr_d     = '0;
            pre_cnt_d    = '0;
            have_prev_d  = 1'b0;
            pend_force_d = 1'b0;
            triggered_d  = 1'b0;
            capt_done_d  = 1'b0;
            state_d      = (pretrig == '0) ? S_WAIT_TRIG : S_PREFILL;
        end else begin
            if ((state_q == S_PREFILL || state_q == S_WAIT_TRIG || state_q == S_POST) && s_if.s_valid) begin
                wr_en       = 1'b1;
                wr_ptr_d    = wr_ptr_q + 1'b1;
                prev_d      = s_if.s_data;
                have_prev_d = 1'b1;
            end
            case (state_q)
                S_PREFILL: begin
                    if (force_trig)
                        pend_force_d = 1'b1;
                    if (s_if.s_valid) begin
                        pre_cnt_d = pre_cnt_q + 1'b1;
                        if (pre_cnt_d == {1'b0, pretrig_q})
                            state_d = S_WAIT_TRIG;
                    end
                end
                S_WAIT_TRIG: begin
                    if (s_if.s_valid && (lvl_hit || force_trig || pend_force_q)) begin
                        start_ptr_d  = wr_ptr_q - pretrig_q;
                        post_cnt_d   = post_init;
                        triggered_d  = 1'b1;
                        pend_force_d = 1'b0;
                        if (post_init == '0) begin
                            capt_done_d = 1'b1;
                            state_d     = S_DONE;
                        end else begin
                            state_d = S_POST;
                        end
                    end else if (force_trig) begin
                        // a force with no sample this cycle applies to the next sample
                        pend_force_d = 1'b1;
                    end
                end
                S_POST: begin
                    if (s_if.s_valid) begin
                        post_cnt_d = post_cnt_q - 1'b1;
                        if (post_cnt_d == '0) begin
                            capt_done_d = 1'b1;
                            state_d     = S_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Logical index 0 maps to the oldest sample of the window.
    always_comb begin
        rd_data_d = mem[start_ptr_q + s_if.rd_addr];
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_q] <= s_if.s_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            start_ptr_q  <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            level_q      <= '0;
            edge_q       <= 1'b0;
            pretrig_q    <= '0;
            prev_q       <= '0;
            have_prev_q  <= 1'b0;
            pend_force_q <= 1'b0;
            triggered_q  <= 1'b0;
            capt_done_q  <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            start_ptr_q  <= start_ptr_d;
            pre_cnt_q    <= pre_cnt_d;
            post_cnt_q   <= post_cnt_d;
            level_q      <= level_d;
            edge_q       <= edge_d;
            pretrig_q    <= pretrig_d;
            prev_q       <= prev_d;
            have_prev_q  <= have_prev_d;
            pend_force_q <= pend_force_d;
            triggered_q  <= triggered_d;
            capt_done_q  <= capt_done_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign busy         = (state_q == S_PREFILL) || (state_q == S_WAIT_TRIG) || (state_q == S_POST);
    assign triggered    = triggered_q;
    assign capt_done    = capt_done_q;
    assign s_if.rd_data = rd_data_q;
endmodule

// File: doc/trig_capture.md
Name: trig_capture

Overview:
- Trigger-and-capture stage directly downstream of the filter block. Consumes the filtered sample stream: each filter `done` strobe is one valid `result` word.
- Detects an edge trigger at a programmable level with a programmable pre-trigger depth. Stores one full window of DEPTH samples in an internal circular buffer.
- Exposes the window, re-ordered oldest-first, through a registered read port for the display/readout logic.

Parameters:
- DATA_SIZE, 16, sample width (matches filter result width).
- ADDR_SIZE, 10, buffer address width.
- DEPTH, 2**ADDR_SIZE, capture window length in samples.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- arm  in  1  single-cycle pulse; starts (or restarts) a capture and samples the configuration inputs.
- trig_level  in  DATA_SIZE  unsigned trigger threshold.
- trig_edge  in  1  0 = rising, 1 = falling.
- pretrig  in  ADDR_SIZE  number of samples kept before the trigger sample (0..DEPTH-1).
- force_trig  in  1  pulse; forces a trigger (auto mode).
- s_valid  in  1  sample strobe (filter done).
- s_data  in  DATA_SIZE  sample value (filter result).
- rd_addr  in  ADDR_SIZE  logical read index; 0 = oldest sample of the window.
- rd_data  out  DATA_SIZE  window sample; 1-cycle registered latency.
- busy  out  1  high in PREFILL, WAIT_TRIG, POST.
- triggered  out  1  set when the trigger sample is written; cleared by arm.
- capt_done  out  1  window complete; held until arm.

Behaviour:
- Reset (async, rstn=0): state IDLE; busy, triggered, capt_done, rd_data = 0; all pointers and counters = 0; pending-force and have_prev cleared. Memory contents are not reset.
- States: IDLE, PREFILL, WAIT_TRIG, POST, DONE.
- arm in any state:
  - Latches trig_level, trig_edge, pretrig.
  - wr_ptr = 0, pre_cnt = 0, have_prev = 0; clears triggered, capt_done, pending-force.
  - Next state is PREFILL, or WAIT_TRIG if pretrig == 0.
  - arm wins over a simultaneous s_valid; that sample is discarded.
- Write rule: in PREFILL, WAIT_TRIG and POST, each s_valid writes s_data to mem[wr_ptr]. wr_ptr increments mod DEPTH. The sample is stored as prev, and have_prev = 1. Samples are ignored in IDLE and DONE.
- PREFILL: pre_cnt increments per sample. When the write makes pre_cnt == pretrig, go to WAIT_TRIG. force_trig here sets pending-force.
- WAIT_TRIG: a written sample is the trigger when any of the following holds:
  - rising: have_prev and prev < level and cur >= level;
  - falling: have_prev and prev >= level and cur < level;
  - force_trig in the same cycle, or pending-force set.
  - Simultaneous level and force triggers count as one trigger.
- On the trigger write:
  - start_ptr = (wr_ptr - pretrig) mod DEPTH.
  - post_cnt = DEPTH - 1 - pretrig.
  - triggered = 1.
  - Next state is POST, or DONE (capt_done = 1) if post_cnt == 0.
- Buffer wrap: writes wrap freely in WAIT_TRIG; older samples are overwritten.
- POST: each sample decrements post_cnt. The write that brings post_cnt to 0 goes to DONE with capt_done = 1, registered on that edge.
- Window size: exactly DEPTH samples. The trigger sample sits at logical index pretrig.
- Read port: rd_data <= mem[(start_ptr + rd_addr) mod DEPTH] every cycle. Data is valid for readout while in DONE.
- Widths: pre_cnt and post_cnt are ADDR_SIZE+1 bits. Comparisons are unsigned.

Test Plan (ADDR_SIZE=4, DEPTH=16):
1. Rising edge:
   - Stimulus: arm with pretrig=4, level=0x0800, edge=0; ramp 0x0000, 0x0100, ... one sample per 3 cycles.
   - Response: triggered on the 0x0800 write; capt_done on the 0x1300 write.
   - Readback: rd_addr 0 = 0x0400, rd_addr 4 = 0x0800, rd_addr 15 = 0x1300, each 1 cycle after the address.
2. Falling edge:
   - Stimulus: pretrig=2, level=0x0500, edge=1; descending ramp 0x0A00 step -0x0100.
   - Response: trigger on 0x0400; rd_addr 2 = 0x0400, rd_addr 0 = 0x0600.
3. pretrig=0:
   - Stimulus: rising level 0x0010; samples 0x0000 then 0x0020.
   - Response: 0x0020 is the trigger; rd_addr 0 = 0x0020; no trigger on the first sample (have_prev=0).
4. Force:
   - Stimulus: constant 0x1234; force_trig pulsed during PREFILL (pretrig=3).
   - Response: trigger on the 4th sample; capture completes with all reads = 0x1234.
5. Maximum pretrig with wrap:
   - Stimulus: pretrig=15; 40 sub-threshold samples (0x0000..0x0027, level 0x8000), then 0x9000.
   - Response: capt_done the same edge as the trigger write; rd_addr 15 = 0x9000, rd_addr 0 = 0x0019.
6. Reset and re-arm:
   - rstn low mid-POST: busy, triggered, capt_done drop immediately; further s_valid is ignored.
   - arm during POST: triggered clears and capture restarts from PREFILL.
